// File: rtl/dac_bus_pkg.sv
// -----------------------------------------------------------------------------
// dac_bus_pkg
// Shared types and defaults for the parallel-bus DAC write sequencer.
//   state_t      : sequencer states. RB_SETUP/RB_STROBE exist only when
//                  DAC_READBACK_EN is defined.
//   dac_pins_t   : bundle of the active-low / direction control pins.
//   DAC_PIN_IDLE : inactive level of CS, RW, LDAC and CLR (all high).
//   DEF_*        : default data/address widths and phase lengths in cycles.
//   max_cyc      : largest of the five phase lengths; sizes the phase timer.
// -----------------------------------------------------------------------------
package dac_bus_pkg;

   typedef enum logic [3:0] {
      INIT,
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      LOAD,
      CLEAR
`ifdef DAC_READBACK_EN
      ,
      RB_SETUP,
      RB_STROBE
`endif
   } state_t;

   typedef struct packed {
      logic cs;
      logic rw;
      logic ldac;
      logic clr;
   } dac_pins_t;

   localparam dac_pins_t DAC_PIN_IDLE = '{cs: 1'b1, rw: 1'b1, ldac: 1'b1, clr: 1'b1};

   localparam int DEF_DATA_W     = 12;
   localparam int DEF_ADDR_W     = 2;
   localparam int DEF_SETUP_CYC  = 1;
   localparam int DEF_STROBE_CYC = 1;
   localparam int DEF_HOLD_CYC   = 1;
   localparam int DEF_LDAC_CYC   = 1;
   localparam int DEF_CLR_CYC    = 2;

   function automatic int max_cyc(input int a, input int b, input int c,
                                  input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

endpackage

// File: rtl/dac_phase_timer.sv
// -----------------------------------------------------------------------------
// dac_phase_timer
// Loadable down-counter shared by every sequencer phase. A phase of N cycles
// loads N-1 on entry; the phase ends on the cycle where the count is zero.
// The counter holds at zero until reloaded.
// Ports:
//   clk      in  clock
//   ld       in  load ld_val this cycle (takes priority over counting)
//   ld_val   in  value to load
//   zero     out current count is zero (last cycle of the phase)
//   zero_nxt out count after this edge will be zero
// -----------------------------------------------------------------------------
module dac_phase_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_val,
   output logic             zero,
   output logic             zero_nxt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = ld_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign zero     = (cnt_q == '0);
   assign zero_nxt = (cnt_d == '0);

endmodule

// File: rtl/dac_bus_sequencer.sv
// -----------------------------------------------------------------------------
// dac_bus_sequencer
// Parallel-bus DAC write sequencer. Accepts one channel write per valid/ready
// handshake and drives AD/DB/RW/CS with programmable setup/strobe/hold
// timing, followed by an LDAC update unless the write is deferred. Deferred
// writes are tracked in a pending-channel mask; the last code written to each
// channel is mirrored in a shadow register. Level requests ldac_req/clr_req
// issue a global LDAC update or a CLR pulse.
//
// Optional feature macro: DAC_READBACK_EN
//   defined   : DB splits into DB_o/DB_i/DB_oe; each write is read back and a
//               mismatch sets the sticky rb_err flag.
//   undefined : output-only DB, rb_err tied low.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   in_valid/in_ready write handshake; in_addr/in_data/in_defer payload
//   ldac_req, clr_req level requests for an LDAC update / CLR pulse
//   wr_done           pulse on the final cycle of each write/update/clear
//   pending           channels written with defer but not yet loaded
//   shadow            last code per channel, channel 0 in the LSBs
//   rb_err            sticky readback mismatch
//   DB (DB_o/DB_i/DB_oe), AD, RW, CS, LDAC, CLR   DAC pins
// -----------------------------------------------------------------------------
module dac_bus_sequencer
   import dac_bus_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int STROBE_CYC = DEF_STROBE_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC,
   parameter int LDAC_CYC   = DEF_LDAC_CYC,
   parameter int CLR_CYC    = DEF_CLR_CYC
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ADDR_W-1:0]             in_addr,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_defer,
   input  logic                          ldac_req,
   input  logic                          clr_req,
   output logic                          wr_done,
   output logic [(2**ADDR_W)-1:0]        pending,
   output logic [(2**ADDR_W)*DATA_W-1:0] shadow,
   output logic                          rb_err,
`ifdef DAC_READBACK_EN
   output logic [DATA_W-1:0]             DB_o,
   input  logic [DATA_W-1:0]             DB_i,
   output logic                          DB_oe,
`else
   output logic [DATA_W-1:0]             DB,
`endif
   output logic [ADDR_W-1:0]             AD,
   output logic                          RW,
   output logic                          CS,
   output logic                          LDAC,
   output logic                          CLR
);

   localparam int NCH     = 2 ** ADDR_W;
   localparam int MAX_CYC = max_cyc(SETUP_CYC, STROBE_CYC, HOLD_CYC, LDAC_CYC, CLR_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   state_t                        state_q, state_d;
   logic [ADDR_W-1:0]             cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0]             cmd_data_q, cmd_data_d;
   logic                          cmd_defer_q, cmd_defer_d;
   logic                          cmd_vld_q, cmd_vld_d;
   logic [NCH-1:0]                pending_q, pending_d;
   logic [NCH-1:0][DATA_W-1:0]    shadow_q, shadow_d;
   logic [ADDR_W-1:0]             ad_q, ad_d;
   logic [DATA_W-1:0]             db_q, db_d;
   logic                          cs_q, cs_d;
   logic                          rw_q, rw_d;
   logic                          ldac_q, ldac_d;
   logic                          clr_q, clr_d;
   logic                          in_ready_q, in_ready_d;
   logic                          wr_done_q, wr_done_d;
   logic                          finish_wr;
   logic                          tmr_ld;
   logic [CNT_W-1:0]              tmr_ld_val;
   logic                          tmr_zero;
   logic                          tmr_zero_nxt;
`ifdef DAC_READBACK_EN
   logic                          rb_err_q, rb_err_d;
   logic                          db_oe_q, db_oe_d;
`endif

   // Last count value of each timed phase (phase of N cycles counts N-1..0).
   function automatic logic [CNT_W-1:0] phase_last(input state_t s);
      case (s)
         SETUP:     return CNT_W'(SETUP_CYC - 1);
         STROBE:    return CNT_W'(STROBE_CYC - 1);
         HOLD:      return CNT_W'(HOLD_CYC - 1);
         LOAD:      return CNT_W'(LDAC_CYC - 1);
         CLEAR:     return CNT_W'(CLR_CYC - 1);
`ifdef DAC_READBACK_EN
         RB_SETUP:  return CNT_W'(SETUP_CYC - 1);
         RB_STROBE: return CNT_W'(STROBE_CYC - 1);
`endif
         default:   return '0;
      endcase
   endfunction

   dac_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (CLK),
      .ld       (tmr_ld),
      .ld_val   (tmr_ld_val),
      .zero     (tmr_zero),
      .zero_nxt (tmr_zero_nxt)
   );

   always_comb begin
      state_d     = state_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_data_d  = cmd_data_q;
      cmd_defer_d = cmd_defer_q;
      cmd_vld_d   = cmd_vld_q;
      pending_d   = pending_q;
      shadow_d    = shadow_q;
      ad_d        = ad_q;
      db_d        = db_q;
      finish_wr   = 1'b0;
`ifdef DAC_READBACK_EN
      rb_err_d    = rb_err_q;
`endif

      // A handshake always captures the command; it is executed from IDLE
      // once no clear/update request outranks it.
      if (in_valid && in_ready_q) begin
         cmd_addr_d  = in_addr;
         cmd_data_d  = in_data;
         cmd_defer_d = in_defer;
         cmd_vld_d   = 1'b1;
      end

      case (state_q)
         INIT:   if (tmr_zero) state_d = IDLE;
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
            end else if (ldac_req) begin
               state_d = LOAD;
            end else if (cmd_vld_d) begin
               state_d   = SETUP;
               cmd_vld_d = 1'b0;
               ad_d      = cmd_addr_d;
               db_d      = cmd_data_d;
            end
         end
         SETUP:  if (tmr_zero) state_d = STROBE;
         STROBE: if (tmr_zero) state_d = HOLD;
         HOLD: begin
            if (tmr_zero) begin
`ifdef DAC_READBACK_EN
               state_d = RB_SETUP;
`else
               finish_wr = 1'b1;
`endif
            end
         end
`ifdef DAC_READBACK_EN
         RB_SETUP: if (tmr_zero) state_d = RB_STROBE;
         RB_STROBE: begin
            if (tmr_zero) begin
               if (DB_i != cmd_data_q) rb_err_d = 1'b1;
               finish_wr = 1'b1;
            end
         end
`endif
         LOAD:   if (tmr_zero) state_d = IDLE;
         CLEAR:  if (tmr_zero) state_d = IDLE;
         default: state_d = INIT;
      endcase

      if (finish_wr) begin
         if (cmd_defer_q) begin
            pending_d[cmd_addr_q] = 1'b1;
            state_d               = IDLE;
         end else begin
            state_d = LOAD;
         end
      end

      // Phase-entry side effects.
      if (state_d != state_q) begin
         case (state_d)
            HOLD:  shadow_d[cmd_addr_q] = cmd_data_q;
            LOAD:  pending_d = '0;
            CLEAR: begin
               pending_d = '0;
               shadow_d  = '0;
            end
            default: ;
         endcase
      end

      // Reset preloads CLR_CYC (not CLR_CYC-1): the reset cycle itself holds
      // CLR high, the following CLR_CYC cycles of INIT hold it low.
      tmr_ld     = RST || (state_d != state_q);
      tmr_ld_val = RST ? CNT_W'(CLR_CYC) : phase_last(state_d);

      // Pins are registered from the next state so they align with state_q.
`ifdef DAC_READBACK_EN
      cs_d    = !(state_d == STROBE || state_d == RB_STROBE);
      db_oe_d = !(state_d == RB_SETUP || state_d == RB_STROBE);
`else
      cs_d    = (state_d != STROBE);
`endif
      rw_d       = !(state_d == SETUP || state_d == STROBE || state_d == HOLD);
      ldac_d     = (state_d != LOAD);
      clr_d      = !(state_d == CLEAR || state_d == INIT);
      in_ready_d = (state_d == IDLE) && !clr_req && !ldac_req && !cmd_vld_d;

      wr_done_d = 1'b0;
      if (tmr_zero_nxt) begin
         case (state_d)
            LOAD, CLEAR: wr_done_d = 1'b1;
`ifdef DAC_READBACK_EN
            RB_STROBE:   wr_done_d = cmd_defer_d;
`else
            HOLD:        wr_done_d = cmd_defer_d;
`endif
            default:     wr_done_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= INIT;
         cmd_vld_q  <= 1'b0;
         pending_q  <= '0;
         shadow_q   <= '0;
         ad_q       <= '0;
         db_q       <= '0;
         cs_q       <= DAC_PIN_IDLE.cs;
         rw_q       <= DAC_PIN_IDLE.rw;
         ldac_q     <= DAC_PIN_IDLE.ldac;
         clr_q      <= DAC_PIN_IDLE.clr;
         in_ready_q <= 1'b0;
         wr_done_q  <= 1'b0;
`ifdef DAC_READBACK_EN
         rb_err_q   <= 1'b0;
         db_oe_q    <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         cmd_vld_q  <= cmd_vld_d;
         pending_q  <= pending_d;
         shadow_q   <= shadow_d;
         ad_q       <= ad_d;
         db_q       <= db_d;
         cs_q       <= cs_d;
         rw_q       <= rw_d;
         ldac_q     <= ldac_d;
         clr_q      <= clr_d;
         in_ready_q <= in_ready_d;
         wr_done_q  <= wr_done_d;
`ifdef DAC_READBACK_EN
         rb_err_q   <= rb_err_d;
         db_oe_q    <= db_oe_d;
`endif
      end
   end

   // Command payload is only meaningful while cmd_vld or an op is running.
   always_ff @(posedge CLK) begin
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_defer_q <= cmd_defer_d;
   end

   assign in_ready = in_ready_q;
   assign wr_done  = wr_done_q;
   assign pending  = pending_q;
   assign shadow   = shadow_q;
   assign AD       = ad_q;
   assign RW       = rw_q;
   assign CS       = cs_q;
   assign LDAC     = ldac_q;
   assign CLR      = clr_q;
`ifdef DAC_READBACK_EN
   assign DB_o     = db_q;
   assign DB_oe    = db_oe_q;
   assign rb_err   = rb_err_q;
`else
   assign DB       = db_q;
   assign rb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dac_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dac_bus_sequencer
// Self-checking bench for dac_bus_sequencer in its default build.
// A reference model holds the per-channel shadow codes and the pending mask;
// each operation's expected latency and pin pulse widths are derived from
// the configured phase lengths.
// -----------------------------------------------------------------------------
module tb_dac_bus_sequencer;

   localparam int DATA_W   = 12;
   localparam int ADDR_W   = 2;
   localparam int NCH      = 4;
   localparam int T_SETUP  = 1;
   localparam int T_STROBE = 1;
   localparam int T_HOLD   = 1;
   localparam int T_LDAC   = 1;
   localparam int T_CLR    = 2;

   localparam int OP_WR   = 0;
   localparam int OP_LDAC = 1;
   localparam int OP_CLR  = 2;

   logic                   clk = 1'b0;
   logic                   RST;
   logic                   in_valid;
   logic                   in_ready;
   logic [ADDR_W-1:0]      in_addr;
   logic [DATA_W-1:0]      in_data;
   logic                   in_defer;
   logic                   ldac_req;
   logic                   clr_req;
   logic                   wr_done;
   logic [NCH-1:0]         pending;
   logic [NCH*DATA_W-1:0]  shadow;
   logic                   rb_err;
   logic [DATA_W-1:0]      DB;
   logic [ADDR_W-1:0]      AD;
   logic                   RW, CS, LDAC, CLR;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] sh_m [NCH];
   logic [NCH-1:0]    pend_m;

   typedef struct {
      int                kind;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              defer;
      logic [NCH-1:0]    exp_pend;
      int                exp_lat;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   dac_bus_sequencer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETUP_CYC(T_SETUP), .STROBE_CYC(T_STROBE),
      .HOLD_CYC(T_HOLD), .LDAC_CYC(T_LDAC), .CLR_CYC(T_CLR)
   ) dut (
      .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .in_defer(in_defer),
      .ldac_req(ldac_req), .clr_req(clr_req), .wr_done(wr_done),
      .pending(pending), .shadow(shadow), .rb_err(rb_err),
      .DB(DB), .AD(AD), .RW(RW), .CS(CS), .LDAC(LDAC), .CLR(CLR)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [NCH*DATA_W-1:0] sh_pack();
      logic [NCH*DATA_W-1:0] v;
      for (int i = 0; i < NCH; i++) v[i*DATA_W +: DATA_W] = sh_m[i];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NCH; i++) sh_m[i] = '0;
      pend_m = '0;
   endtask

   // Counts CLR-low cycles from reset release until in_ready comes up.
   task automatic init_seq(input string nm);
      int clr_lo;
      int k;
      clr_lo = 0;
      k      = 0;
      do begin
         @(negedge clk);
         if (!CLR) clr_lo++;
         k++;
      end while (!in_ready && k < 20);
      check({nm, "_clr_cycles"}, clr_lo, T_CLR);
      check({nm, "_ready"}, in_ready, 1'b1);
   endtask

   // Issues one operation from IDLE and compares its timing and effect
   // against the reference model.
   task automatic run_op(input int kind, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic df, output int lat);
      int k, cs_lo, ld_lo, cl_lo, exp_lat;
      logic [ADDR_W-1:0] ad_s;
      logic [DATA_W-1:0] db_s;
      logic              rw_s;
      k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("idle_wait", in_ready, 1'b1);
      case (kind)
         OP_WR: begin
            in_valid = 1'b1; in_addr = a; in_data = d; in_defer = df;
         end
         OP_LDAC: ldac_req = 1'b1;
         default: clr_req = 1'b1;
      endcase
      @(negedge clk);
      in_valid = 1'b0; ldac_req = 1'b0; clr_req = 1'b0;
      lat = 0; cs_lo = 0; ld_lo = 0; cl_lo = 0;
      ad_s = '0; db_s = '0; rw_s = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         if (!CS) begin
            cs_lo++; ad_s = AD; db_s = DB; rw_s = RW;
         end
         if (!LDAC) ld_lo++;
         if (!CLR) cl_lo++;
         if (wr_done) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      case (kind)
         OP_WR: begin
            sh_m[a] = d;
            if (df) pend_m[a] = 1'b1;
            else    pend_m = '0;
            exp_lat = T_SETUP + T_STROBE + T_HOLD + (df ? 0 : T_LDAC);
            check("wr_ad", ad_s, a);
            check("wr_db", db_s, d);
            check("wr_rw", rw_s, 1'b0);
            check("wr_cs_low", cs_lo, T_STROBE);
            check("wr_ldac_low", ld_lo, df ? 0 : T_LDAC);
            check("wr_clr_low", cl_lo, 0);
         end
         OP_LDAC: begin
            pend_m  = '0;
            exp_lat = T_LDAC;
            check("ld_ldac_low", ld_lo, T_LDAC);
            check("ld_cs_low", cs_lo, 0);
         end
         default: begin
            model_clear();
            exp_lat = T_CLR;
            check("clr_clr_low", cl_lo, T_CLR);
            check("clr_ldac_low", ld_lo, 0);
         end
      endcase
      check("op_latency", lat, exp_lat);
      @(negedge clk);
      check("op_ready_after", in_ready, 1'b1);
      check("op_done_pulse", wr_done, 1'b0);
      check("op_pins_idle", {CS, LDAC, CLR, RW}, 4'hF);
      check("op_pending", pending, pend_m);
      check("op_shadow", shadow, sh_pack());
   endtask

   initial begin
      int lat, k, r, kind;
      int first_clr, first_ld, first_cs, clr_lo, ld_lo, cs_lo, n_done;

      vecs[0] = '{OP_WR,   2'd2, 12'hABC, 1'b0, 4'b0000, 4};
      vecs[1] = '{OP_WR,   2'd0, 12'h111, 1'b1, 4'b0001, 3};
      vecs[2] = '{OP_WR,   2'd3, 12'hFFF, 1'b1, 4'b1001, 3};
      vecs[3] = '{OP_WR,   2'd3, 12'h123, 1'b1, 4'b1001, 3};
      vecs[4] = '{OP_LDAC, 2'd0, 12'h000, 1'b0, 4'b0000, 1};
      vecs[5] = '{OP_WR,   2'd1, 12'h456, 1'b1, 4'b0010, 3};
      vecs[6] = '{OP_CLR,  2'd0, 12'h000, 1'b0, 4'b0000, 2};

      RST = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_defer = 1'b0;
      ldac_req = 1'b0; clr_req = 1'b0;
      model_clear();

      repeat (3) @(negedge clk);
      check("rst_pins", {CS, RW, LDAC, CLR}, 4'hF);
      check("rst_ad", AD, 0);
      check("rst_db", DB, 0);
      check("rst_ready", in_ready, 1'b0);
      check("rst_done", wr_done, 1'b0);
      check("rst_pending", pending, 0);
      check("rst_shadow", shadow, 0);
      check("rst_rb_err", rb_err, 1'b0);
      RST = 1'b0;
      init_seq("init");

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].kind, vecs[i].addr, vecs[i].data, vecs[i].defer, lat);
         check("tbl_latency", lat, vecs[i].exp_lat);
         check("tbl_pending", pending, vecs[i].exp_pend);
      end

      // clr_req, ldac_req and a write arrive together: clear, then update,
      // then the write.
      run_op(OP_WR, 2'd2, 12'h222, 1'b1, lat);
      clr_req = 1'b1; ldac_req = 1'b1;
      in_valid = 1'b1; in_addr = 2'd1; in_data = 12'h777; in_defer = 1'b1;
      @(negedge clk);
      clr_req = 1'b0; in_valid = 1'b0;
      check("sim_shadow_cleared", shadow, 0);
      check("sim_pending_cleared", pending, 0);
      check("sim_ready_low", in_ready, 1'b0);
      first_clr = -1; first_ld = -1; first_cs = -1;
      clr_lo = 0; ld_lo = 0; cs_lo = 0; n_done = 0;
      for (int c = 0; c < 16; c++) begin
         if (!CLR) begin
            clr_lo++;
            if (first_clr < 0) first_clr = c;
         end
         if (!LDAC) begin
            ld_lo++;
            ldac_req = 1'b0;
            if (first_ld < 0) first_ld = c;
         end
         if (!CS) begin
            cs_lo++;
            if (first_cs < 0) first_cs = c;
         end
         if (wr_done) n_done++;
         @(negedge clk);
      end
      ldac_req = 1'b0;
      model_clear();
      sh_m[1] = 12'h777; pend_m = 4'b0010;
      check("sim_clear_first", first_clr, 0);
      check("sim_ldac_after_clr", (first_ld > first_clr), 1'b1);
      check("sim_write_after_ldac", (first_cs > first_ld), 1'b1);
      check("sim_clr_low", clr_lo, T_CLR);
      check("sim_ldac_low", ld_lo, T_LDAC);
      check("sim_cs_low", cs_lo, T_STROBE);
      check("sim_done_pulses", n_done, 3);
      check("sim_pending", pending, pend_m);
      check("sim_shadow", shadow, sh_pack());

      // Reset in the middle of a strobe aborts and restarts INIT.
      in_valid = 1'b1; in_addr = 2'd0; in_data = 12'h5A5; in_defer = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("abort_cs_in_strobe", CS, 1'b0);
      RST = 1'b1;
      @(negedge clk);
      check("abort_pins", {CS, RW, LDAC, CLR}, 4'hF);
      check("abort_ready", in_ready, 1'b0);
      check("abort_pending", pending, 0);
      check("abort_shadow", shadow, 0);
      RST = 1'b0;
      model_clear();
      init_seq("abort_init");

      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         kind = (r == 0) ? OP_CLR : ((r <= 2) ? OP_LDAC : OP_WR);
         run_op(kind, ADDR_W'($urandom_range(0, NCH - 1)), DATA_W'($urandom),
                1'($urandom_range(0, 1)), lat);
      end

      check("end_rb_err", rb_err, 1'b0);
      k = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
